// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester round-robin front end for a nibble-serial adder.
// A single 4-bit carry-select slice (sum_4) is reused for every nibble of every
// operation, so a WIDTH-bit add takes WIDTH/4 cycles in ADD before the result
// is presented in DONE.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   reqN_valid               requester N has an operation pending
//   reqN_a, reqN_b, reqN_cin requester N operands and carry-in
//   reqN_ready               requester N accepted this cycle (IDLE only)
//   res_valid, res_ready     result handshake
//   res_id                   requester that owns the result
//   res_sum, res_cout        a + b + cin modulo 2^WIDTH, and carry-out
//   busy                     high whenever the FSM is not in IDLE
module serial_add_arb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  // 4-bit carry-select slice: low pair ripples, high pair is precomputed for
  // both carries and selected by the low-pair carry. Returns {cout, sum}.
  function automatic logic [4:0] sum_4(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    lo  = 3'({1'b0, a[1:0]}) + 3'({1'b0, b[1:0]}) + 3'(cin);
    hi0 = 3'({1'b0, a[3:2]}) + 3'({1'b0, b[3:2]});
    hi1 = 3'({1'b0, a[3:2]}) + 3'({1'b0, b[3:2]}) + 3'd1;
    sum_4 = lo[2] ? {hi1, lo[1:0]} : {hi0, lo[1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             pref_q, pref_d;      // requester preferred on a tie
  logic             valid_q, busy_q;
  logic             gnt0, gnt1;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      pref_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      pref_q  <= pref_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state, arbitration and nibble datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    pref_d  = pref_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    a_nib   = '0;
    b_nib   = '0;

    for (int unsigned i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    slice = sum_4(a_nib, b_nib, carry_q);

    unique case (state_q)
      IDLE: begin
        // Requester 0 wins when alone or when it is the preferred one.
        if (req0_valid && (!req1_valid || !pref_q)) begin
          gnt0 = 1'b1;
        end else if (req1_valid) begin
          gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          carry_d = gnt1 ? req1_cin : req0_cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          id_d    = gnt1;
          pref_d  = ~gnt1;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[4*i +: 4] = slice[3:0];
          end
        end
        carry_d = slice[4];
        cnt_d   = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d  = slice[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a same-cycle acknowledge of the grant; forced low while in reset.
  assign req0_ready = reset_n & gnt0;
  assign req1_ready = reset_n & gnt1;
  assign res_valid  = valid_q;
  assign res_id     = id_q;
  assign res_sum    = sum_q;
  assign res_cout   = cout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed and randomized bench for serial_add_arb (WIDTH=16).
module tb_serial_add_arb;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_ready, res_id, res_cout, busy;
  logic [15:0] res_sum;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        id;
    logic [15:0] s;
    logic        c;
  } exp_t;

  exp_t exp_q[$];

  serial_add_arb #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_cout(res_cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A cycle starts just after the rising edge (drive) and is checked mid-cycle.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_grant(input logic eid, input string tag);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    mid();
    while (!got && n < 50) begin
      if (req0_ready || req1_ready) got = 1'b1;
      else begin
        next_cyc();
        mid();
        n++;
      end
    end
    chk({tag, "_grant_seen"}, 32'(got), 32'd1);
    chk({tag, "_grant_both"}, 32'(req0_ready & req1_ready), 32'd0);
    chk({tag, "_grant_id"}, 32'(req1_ready), 32'(eid));
  endtask

  // Waits for res_valid; n0 is the number of cycles already spent since the grant.
  task automatic expect_result(input int n0, input logic eid, input logic [15:0] es,
                               input logic ec, input string tag);
    int n;
    logic stray;
    n = n0;
    stray = 1'b0;
    mid();
    while (!res_valid && n < 40) begin
      if (req0_ready || req1_ready) stray = 1'b1;
      next_cyc();
      mid();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_ready_busy"}, 32'(stray), 32'd0);
    chk({tag, "_id"}, 32'(res_id), 32'(eid));
    chk({tag, "_sum"}, 32'(res_sum), 32'(es));
    chk({tag, "_cout"}, 32'(res_cout), 32'(ec));
  endtask

  task automatic single_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] es, input logic ec,
                           input string tag);
    next_cyc();
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    expect_grant(id, tag);
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    expect_result(1, id, es, ec, tag);
  endtask

  initial begin
    logic        vld[2];
    logic [15:0] ra[2];
    logic [15:0] rb[2];
    logic        rc[2];
    logic [16:0] t;
    exp_t        e;
    int          done;
    int          cyc;

    // Reset state, with a request already pending
    reset_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0FCD; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_sum", 32'(res_sum), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    next_cyc();
    next_cyc();

    // Grant in the release cycle; first operation with mid-ADD partial sums
    next_cyc();
    reset_n = 1'b1; res_ready = 1'b1;
    mid();
    chk("op1_ready0", 32'(req0_ready), 32'd1);
    chk("op1_ready1", 32'(req1_ready), 32'd0);
    next_cyc();
    req0_valid = 1'b0;
    mid();
    chk("op1_busy", 32'(busy), 32'd1);
    chk("op1_sum_k0", 32'(res_sum), 32'h0000);
    next_cyc();
    mid();
    chk("op1_sum_k1", 32'(res_sum), 32'h0001);
    next_cyc();
    expect_result(3, 1'b0, 16'h2201, 1'b0, "op1");

    single_op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "op2");
    single_op(1'b1, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, "op3");
    single_op(1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, "op4");
    single_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");

    // Round robin with both requesters held valid
    next_cyc();
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'hF000; req1_b = 16'h2000; req1_cin = 1'b1;
    expect_grant(1'b0, "rr0");
    next_cyc();
    expect_result(1, 1'b0, 16'h0003, 1'b0, "rr0");
    next_cyc();
    expect_grant(1'b1, "rr1");
    next_cyc();
    expect_result(1, 1'b1, 16'h1001, 1'b1, "rr1");
    next_cyc();
    expect_grant(1'b0, "rr2");
    next_cyc();
    expect_result(1, 1'b0, 16'h0003, 1'b0, "rr2");
    next_cyc();
    expect_grant(1'b1, "rr3");
    next_cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    expect_result(1, 1'b1, 16'h1001, 1'b1, "rr3");

    // Backpressure in DONE with req1 pending
    next_cyc();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h4321; req0_b = 16'h1234; req0_cin = 1'b0;
    expect_grant(1'b0, "bp");
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0FFF; req1_b = 16'h0001; req1_cin = 1'b0;
    expect_result(1, 1'b0, 16'h5555, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      mid();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_sum", 32'(res_sum), 32'h5555);
      chk("bp_hold_busy", 32'(busy), 32'd1);
      chk("bp_hold_ready1", 32'(req1_ready), 32'd0);
    end
    next_cyc();
    res_ready = 1'b1;
    mid();
    chk("bp_hs_valid", 32'(res_valid), 32'd1);
    chk("bp_hs_ready1", 32'(req1_ready), 32'd0);
    next_cyc();
    mid();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(res_valid), 32'd0);
    chk("bp_next_grant", 32'(req1_ready), 32'd1);
    next_cyc();
    req1_valid = 1'b0;
    expect_result(1, 1'b1, 16'h1000, 1'b0, "bp_next");

    // Reset during ADD nibble 2 of a req0 operation
    next_cyc();
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    expect_grant(1'b0, "rst_op");
    next_cyc();
    req0_a = 16'h0F0F; req0_b = 16'h0101;
    req1_valid = 1'b1; req1_a = 16'h7000; req1_b = 16'h9000; req1_cin = 1'b0;
    next_cyc();
    next_cyc();
    mid();
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_sum", 32'(res_sum), 32'h0033);
    reset_n = 1'b0;
    #1;
    chk("rst_now_busy", 32'(busy), 32'd0);
    chk("rst_now_sum", 32'(res_sum), 32'd0);
    chk("rst_now_valid", 32'(res_valid), 32'd0);
    chk("rst_now_readies", 32'({req0_ready, req1_ready}), 32'd0);
    next_cyc();
    mid();
    chk("rst_hold_busy", 32'(busy), 32'd0);
    next_cyc();
    reset_n = 1'b1;
    mid();
    chk("rst_rel_ready0", 32'(req0_ready), 32'd1);
    chk("rst_rel_ready1", 32'(req1_ready), 32'd0);
    next_cyc();
    req0_valid = 1'b0;
    expect_result(1, 1'b0, 16'h1010, 1'b0, "rst_after0");
    next_cyc();
    expect_grant(1'b1, "rst_after1");
    next_cyc();
    req1_valid = 1'b0;
    expect_result(1, 1'b1, 16'h0000, 1'b1, "rst_after1");

    // Random operations against a+b+cin, in grant order
    vld[0] = 1'b0; vld[1] = 1'b0;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rc[0] = 1'b0; rc[1] = 1'b0;
    done = 0;
    cyc = 0;
    while (done < 1000 && cyc < 60000) begin
      next_cyc();
      cyc++;
      for (int r = 0; r < 2; r++) begin
        if (!vld[r] && ($urandom_range(0, 1) == 1)) begin
          vld[r] = 1'b1;
          ra[r] = 16'($urandom);
          rb[r] = 16'($urandom);
          rc[r] = 1'($urandom_range(0, 1));
        end
      end
      req0_valid = vld[0]; req0_a = ra[0]; req0_b = rb[0]; req0_cin = rc[0];
      req1_valid = vld[1]; req1_a = ra[1]; req1_b = rb[1]; req1_cin = rc[1];
      res_ready = ($urandom_range(0, 3) != 0);
      mid();
      if (req0_ready || req1_ready) begin
        chk("rand_onehot", 32'(req0_ready & req1_ready), 32'd0);
        chk("rand_ready_valid", 32'((req0_ready & !vld[0]) | (req1_ready & !vld[1])), 32'd0);
        for (int r = 0; r < 2; r++) begin
          if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
            t = 17'(ra[r]) + 17'(rb[r]) + 17'(rc[r]);
            e.id = 1'(r);
            e.s = t[15:0];
            e.c = t[16];
            exp_q.push_back(e);
            vld[r] = 1'b0;
          end
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_result", 32'({res_id, res_sum, res_cout}), 32'({e.id, e.s, e.c}));
        end
        done++;
      end
    end
    chk("rand_done", 32'(done), 32'd1000);
    chk("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
